// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

   localparam int unsigned SERIAL_ADDER_WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/fa.sv
// Single-bit combinational full-adder cell.
module fa (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic carry
);

   assign s     = a ^ b ^ ci;
   assign carry = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one fa cell, LSB-first, WIDTH cycles per addition.
// Optional SERIAL_ADDER_OVF_EN adds a registered signed-overflow output ovf.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = SERIAL_ADDER_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   state_e           state_q;
   state_e           state_d;
   logic [WIDTH-1:0] sa_q;
   logic [WIDTH-1:0] sb_q;
   logic             carry_q;
   logic [CNT_W-1:0] cnt_q;
   logic             fa_s;
   logic             fa_carry;
   logic             last_c;

   assign last_c = (cnt_q == CNT_W'(WIDTH - 1));

   fa u_fa (
      .a     (sa_q[0]),
      .b     (sb_q[0]),
      .ci    (carry_q),
      .s     (fa_s),
      .carry (fa_carry)
   );

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = SHIFT;
         SHIFT:   if (last_c) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Datapath and registered status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy    <= 1'b0;
         done    <= 1'b0;
         sum     <= '0;
         cout    <= 1'b0;
         sa_q    <= '0;
         sb_q    <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf     <= 1'b0;
`endif
      end else begin
         busy <= (state_d == SHIFT);
         done <= (state_d == DONE);
         case (state_q)
            IDLE: begin
               if (start) begin
                  sa_q    <= a;
                  sb_q    <= b;
                  carry_q <= cin;
                  cnt_q   <= '0;
                  sum     <= '0;
                  cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
                  ovf     <= 1'b0;
`endif
               end
            end
            SHIFT: begin
               sum     <= {fa_s, sum[WIDTH-1:1]};
               carry_q <= fa_carry;
               sa_q    <= {1'b0, sa_q[WIDTH-1:1]};
               sb_q    <= {1'b0, sb_q[WIDTH-1:1]};
               cnt_q   <= cnt_q + CNT_W'(1);
               if (last_c) begin
                  cout <= fa_carry;
`ifdef SERIAL_ADDER_OVF_EN
                  // carry_q here is the carry into the MSB
                  ovf  <= carry_q ^ fa_carry;
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder against a plain-arithmetic reference.
module tb_serial_adder;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic       busy;
   logic       done;
   logic [7:0] sum;
   logic       cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic       ovf;
`endif

   int checks = 0;
   int errors = 0;

   serial_adder #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: integer addition, signed overflow from operand/result signs
   function automatic logic [8:0] ref_add(input logic [7:0] x, input logic [7:0] y, input logic c);
      int unsigned t;
      t = int'(x) + int'(y) + int'(c);
      return t[8:0];
   endfunction

   function automatic logic ref_ovf(input logic [7:0] x, input logic [7:0] y, input logic c);
      int sx, sy, st;
      sx = int'($signed(x));
      sy = int'($signed(y));
      st = sx + sy + int'(c);
      return (st > 127) || (st < -128);
   endfunction

   task automatic check_result(input string tag, input logic [7:0] x, input logic [7:0] y, input logic c);
      logic [8:0] r;
      r = ref_add(x, y, c);
      check({tag, "_sum"}, 32'(sum), 32'(r[7:0]));
      check({tag, "_cout"}, 32'(cout), 32'(r[8]));
`ifdef SERIAL_ADDER_OVF_EN
      check({tag, "_ovf"}, 32'(ovf), 32'(ref_ovf(x, y, c)));
`endif
   endtask

   // One full transaction with latency, busy-length and done-pulse checks
   task automatic do_add(input string tag, input logic [7:0] x, input logic [7:0] y, input logic c);
      int  n_busy;
      bit  seen;
      @(negedge clk);
      a = x; b = y; cin = c; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      n_busy = 0;
      seen   = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (busy) n_busy++;
         @(negedge clk);
      end
      check({tag, "_done_seen"}, 32'(seen), 32'd1);
      if (seen) begin
         check({tag, "_busy_len"}, 32'(n_busy), 32'd8);
         check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
         check_result(tag, x, y, c);
         @(negedge clk);
         check({tag, "_done_pulse"}, 32'(done), 32'd0);
         check_result({tag, "_hold"}, x, y, c);
      end
   endtask

   initial begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rc;
      bit         seen;
      bit         done_in_reset;

      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_sum", 32'(sum), 32'd0);
      check("reset_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
      check("reset_ovf", 32'(ovf), 32'd0);
`endif
      rst_n = 1'b1;
      @(negedge clk);

      do_add("t35_4a", 8'h35, 8'h4A, 1'b0);
      do_add("tff_01", 8'hFF, 8'h01, 1'b0);
      do_add("tff_00c", 8'hFF, 8'h00, 1'b1);
      do_add("t7f_01", 8'h7F, 8'h01, 1'b0);
      do_add("t80_80", 8'h80, 8'h80, 1'b0);
      do_add("t00_00", 8'h00, 8'h00, 1'b0);
      do_add("tff_ffc", 8'hFF, 8'hFF, 1'b1);

      // start held high; operands change at E0+3 must be ignored
      @(negedge clk);
      a = 8'h5C; b = 8'hA7; cin = 1'b1; start = 1'b1;
      @(posedge clk);
      for (int k = 0; k <= 10; k++) begin
         @(negedge clk);
         if (k == 2) begin
            a = 8'h21; b = 8'h43; cin = 1'b0;
         end
         if (k == 8) begin
            check("hold_done", 32'(done), 32'd1);
            check_result("hold_first", 8'h5C, 8'hA7, 1'b1);
         end
         if (k == 9) begin
            check("hold_idle_done", 32'(done), 32'd0);
            check("hold_idle_busy", 32'(busy), 32'd0);
         end
         if (k == 10) begin
            check("hold_accept", 32'(busy), 32'd1);
            start = 1'b0;
         end
      end
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("hold_second_done", 32'(seen), 32'd1);
      if (seen) check_result("hold_second", 8'h21, 8'h43, 1'b0);
      @(negedge clk);

      // reset mid-operation
      @(negedge clk);
      a = 8'hC3; b = 8'h5A; cin = 1'b1; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_sum", 32'(sum), 32'd0);
      check("midrst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
      check("midrst_ovf", 32'(ovf), 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      done_in_reset = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (done || busy) done_in_reset = 1'b1;
      end
      check("midrst_no_done", 32'(done_in_reset), 32'd0);
      do_add("post_rst", 8'h12, 8'h34, 1'b0);
      check("post_rst_val", 32'(sum), 32'h46);

      for (int i = 0; i < 20; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rc = 1'($urandom);
         do_add($sformatf("rnd%0d", i), ra, rb, rc);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
